// File: rtl/mem_mmu_ptw_if.sv
// mem_mmu_ptw_if: request/response handshake and page-table read port of the MMU walker.
// master = requester and page-table memory side, slave = mem_mmu_ptw.
interface mem_mmu_ptw_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic        req_write;
    logic [1:0]  priv_mode;
    logic [31:0] satp;
    logic        sfence;
    logic        rsp_valid;
    logic [31:0] rsp_paddr;
    logic        rsp_fault;
    logic        ptw_rd_en;
    logic [31:0] ptw_rd_addr;
    logic [31:0] ptw_rd_data;

    modport master (
        output req_valid, req_vaddr, req_write, priv_mode, satp, sfence, ptw_rd_data,
        input  req_ready, rsp_valid, rsp_paddr, rsp_fault, ptw_rd_en, ptw_rd_addr
    );

    modport slave (
        input  req_valid, req_vaddr, req_write, priv_mode, satp, sfence, ptw_rd_data,
        output req_ready, rsp_valid, rsp_paddr, rsp_fault, ptw_rd_en, ptw_rd_addr
    );
endinterface

// File: rtl/mem_mmu_ptw.sv
// mem_mmu_ptw: two-level page-table walker with an optional fully-associative TLB.
// Define MMU_TLB_EN to build the TLB; without it every translated access walks.
module mem_mmu_ptw #(
    parameter int TLB_ENTRIES = 4
) (
    input logic          clk,
    input logic          rstn,
    mem_mmu_ptw_if.slave bus
);
    typedef enum logic [2:0] {IDLE, L1_RD, L1_CHK, L2_RD, L2_CHK, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] vaddr_q, paddr_q, rd_addr_q, pte;
    logic        wr_q, fault_q, fill_q, w_q, sf_q;
    logic        accept, bypass, hit, hit_w, hit_fault, do_fill;
    logic [19:0] hit_ppn;
    logic        pte_v, pte_r, pte_w, pte_x, pte_bad, pte_leaf, sp_fault, l2_fault;
    logic        unused_bits;

    assign pte                              = bus.ptw_rd_data;
    assign {pte_x, pte_w, pte_r, pte_v}     = pte[3:0];
    assign pte_bad   = !pte_v || (!pte_r && pte_w);
    assign pte_leaf  = pte_r || pte_x;
    assign sp_fault  = wr_q && !pte_w;
    assign l2_fault  = pte_bad || !pte_leaf || (wr_q && !pte_w);
    assign accept    = bus.req_valid && bus.req_ready;
    assign bypass    = bus.priv_mode == 2'b11 || !bus.satp[31];
    assign hit_fault = bus.req_write && !hit_w;
    // A fill is dropped if sfence was seen anywhere in the walk, including the DONE cycle itself.
    assign do_fill   = state == DONE && fill_q && !sf_q && !bus.sfence;
    assign unused_bits = ^{bus.satp[30:20], pte[31:30], pte[9:4]};

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !accept ? IDLE : (bypass || hit) ? DONE : L1_RD;
            L1_RD:   state_nx = L1_CHK;
            L1_CHK:  state_nx = (pte_bad || pte_leaf) ? DONE : L2_RD;
            L2_RD:   state_nx = L2_CHK;
            L2_CHK:  state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = state == IDLE;
        bus.ptw_rd_en   = state == L1_RD || state == L2_RD;
        bus.rsp_valid   = state == DONE;
        bus.rsp_paddr   = paddr_q;
        bus.rsp_fault   = fault_q;
        bus.ptw_rd_addr = rd_addr_q;
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            vaddr_q   <= '0;
            wr_q      <= 1'b0;
            paddr_q   <= '0;
            fault_q   <= 1'b0;
            rd_addr_q <= '0;
            fill_q    <= 1'b0;
            w_q       <= 1'b0;
            sf_q      <= 1'b0;
        end else begin
            sf_q <= accept ? bus.sfence : sf_q || bus.sfence;
            if (accept) begin
                vaddr_q <= bus.req_vaddr;
                wr_q    <= bus.req_write;
                fill_q  <= 1'b0;
                fault_q <= !bypass && hit && hit_fault;
                paddr_q <= bypass ? bus.req_vaddr :
                           (hit && !hit_fault) ? {hit_ppn, bus.req_vaddr[11:0]} : '0;
                if (!bypass && !hit) rd_addr_q <= {bus.satp[19:0], bus.req_vaddr[31:22], 2'b00};
            end else if (state == L1_CHK) begin
                fault_q   <= pte_bad || (pte_leaf && sp_fault);
                paddr_q   <= (pte_bad || sp_fault) ? '0 : {pte[29:20], vaddr_q[21:0]};
                rd_addr_q <= {pte[29:10], vaddr_q[21:12], 2'b00};
            end else if (state == L2_CHK) begin
                fault_q <= l2_fault;
                paddr_q <= l2_fault ? '0 : {pte[29:10], vaddr_q[11:0]};
                fill_q  <= !l2_fault;
                w_q     <= pte_w;
            end
        end

`ifdef MMU_TLB_EN
    localparam int IW = $clog2(TLB_ENTRIES);

    logic [TLB_ENTRIES-1:0] tlb_v, tlb_w;
    logic [19:0]            tlb_tag [TLB_ENTRIES];
    logic [19:0]            tlb_ppn [TLB_ENTRIES];
    logic [IW-1:0]          rr, fill_idx;
    logic                   any_free;

    always_comb begin
        hit     = 1'b0;
        hit_ppn = '0;
        hit_w   = 1'b0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--)
            if (tlb_v[i] && tlb_tag[i] == bus.req_vaddr[31:12]) begin
                hit     = 1'b1;
                hit_ppn = tlb_ppn[i];
                hit_w   = tlb_w[i];
            end
    end

    // Lowest free slot wins; the round-robin pointer is used only when the TLB is full.
    always_comb begin
        any_free = 1'b0;
        fill_idx = rr;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--)
            if (!tlb_v[i]) begin
                any_free = 1'b1;
                fill_idx = IW'(i);
            end
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            tlb_v <= '0;
            rr    <= '0;
        end else if (bus.sfence) begin
            tlb_v <= '0;
        end else if (do_fill) begin
            tlb_v[fill_idx] <= 1'b1;
            if (!any_free) rr <= rr + 1'b1;
        end

    always_ff @(posedge clk)
        if (do_fill) begin
            tlb_tag[fill_idx] <= vaddr_q[31:12];
            tlb_ppn[fill_idx] <= paddr_q[31:12];
            tlb_w[fill_idx]   <= w_q;
        end
`else
    logic unused_cfg;

    assign hit        = 1'b0;
    assign hit_ppn    = '0;
    assign hit_w      = 1'b0;
    assign unused_cfg = ^{vaddr_q[31:22], w_q, do_fill, TLB_ENTRIES};
`endif
endmodule
